// File: rtl/data_mem_responder_if.sv
// Load/store request and response bus between a requester (master) and the
// data memory responder (slave).
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both 1; once valid is raised, the sender holds valid
// and all payload signals stable until that edge.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_rd, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_rd, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with a fixed, parameterised wait
// between request accept and response.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned word
// accesses (no write, zero data, rsp_err = 1, same timing).
// state_dbg exposes the FSM state: 0 = IDLE, 1 = WAIT, 2 = RESP.
module data_mem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   data_mem_responder_if.slave    bus,
   output logic [1:0]             state_dbg
);

   localparam int         AW  = $clog2(DEPTH);
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [4:0]    rd_q;

   logic          rsp_valid_q;
   logic [31:0]   rsp_data_q;
   logic [4:0]    rsp_rd_q;
   logic          rsp_err_q;

   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          enter_resp;
   logic          rsp_hs;

   // Access operands: with zero latency the access happens on the accept edge
   // itself, so the live request fields are used instead of the latched copy.
   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [4:0]    acc_rd;
   logic [AW-1:0] acc_idx;
   logic          acc_err;
   logic          unused_addr_bits;

   assign acc_we    = (state == IDLE) ? bus.req_we    : we_q;
   assign acc_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
   assign acc_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
   assign acc_rd    = (state == IDLE) ? bus.req_rd    : rd_q;
   assign acc_idx   = acc_addr[AW+1:2];

   // Upper address bits wrap; byte-offset bits only matter with the align check.
   assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   assign acc_err = |acc_addr[1:0];
`else
   assign acc_err = 1'b0;
`endif

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_rd    = rsp_rd_q;
   assign bus.rsp_err   = rsp_err_q;
   assign state_dbg     = state;

   // Next-state logic and the accept / access / handshake strobes.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      enter_resp = 1'b0;
      rsp_hs     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept = 1'b1;
               if (LAT == 4'd0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_hs    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state, request latch, wait counter and response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rd_q        <= 5'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_rd_q    <= 5'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rd_q    <= bus.req_rd;
            cnt     <= LAT;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            rsp_valid_q <= 1'b1;
            rsp_rd_q    <= acc_rd;
            rsp_err_q   <= acc_err;
            rsp_data_q  <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
         end else if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   // Memory array: cleared by reset, written only on the edge entering RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
         end
      end else if (enter_resp && acc_we && !acc_err) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

endmodule
